// File: rtl/addsub_share_arbiter.sv
// =====================================================================
// addsub_share_arbiter: round-robin sharing of one 20-bit CLA add/sub
// unit among NREQ requesters. Revision: 1.0
// =====================================================================
`default_nettype none

module carry_lookahead_adder_20bit (
    input  logic [19:0] a_i,
    input  logic [19:0] b_i,
    input  logic        sub_i,
    input  logic        cin_i,
    output logic [19:0] sum_o,
    output logic        cout_o,
    output logic        v_o
);
    logic [19:0] bx, p, g, cb;
    logic [4:0]  grp_g, grp_p;
    logic [5:0]  gc;

    assign bx = b_i ^ {20{sub_i}};
    assign p  = a_i ^ bx;
    assign g  = a_i & bx;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_grp
            logic [3:0] gp, gg;
            assign gp = p[4*gi +: 4];
            assign gg = g[4*gi +: 4];
            assign cb[4*gi]   = gc[gi];
            assign cb[4*gi+1] = gg[0] | (gp[0] & gc[gi]);
            assign cb[4*gi+2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[gi]);
            assign cb[4*gi+3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                              | (gp[2] & gp[1] & gp[0] & gc[gi]);
            assign grp_g[gi]  = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                              | (gp[3] & gp[2] & gp[1] & gg[0]);
            assign grp_p[gi]  = &gp;
        end
    endgenerate

    // Group carries: subtraction supplies the +1 of two's-complement negation
    always_comb begin
        gc[0] = cin_i | sub_i;
        for (int i = 0; i < 5; i++) begin
            gc[i+1] = grp_g[i] | (grp_p[i] & gc[i]);
        end
    end

    assign sum_o  = p ^ cb;
    assign cout_o = gc[5];
    assign v_o    = gc[5] ^ cb[19];
endmodule

module addsub_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    sub_bus,
    input  logic [NREQ*20-1:0] a_bus,
    input  logic [NREQ*20-1:0] b_bus,
    output logic [NREQ-1:0]    gnt,
    output logic               done,
    output logic [IDW-1:0]     done_id,
    output logic [19:0]        result,
    output logic               res_cout,
    output logic               res_v,
    output logic               busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

    state_t          state_q, state_d;
    logic [IDW-1:0]  last_q, last_d, id_q, id_d, done_id_q, done_id_d;
    logic [19:0]     a_q, a_d, b_q, b_d, result_q, result_d;
    logic            sub_q, sub_d, done_q, done_d, cout_q, cout_d, v_q, v_d;
    logic            busy_q, busy_d;
    logic [NREQ-1:0] gnt_q, gnt_d;

    logic [19:0]     add_sum;
    logic            add_cout, add_v;
    logic            win_vld;
    logic [IDW-1:0]  win_id, arb_sel;

    carry_lookahead_adder_20bit u_adder (
        .a_i    (a_q),
        .b_i    (b_q),
        .sub_i  (sub_q),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout),
        .v_o    (add_v)
    );

    // First requester found when scanning from last+1 around the ring
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        arb_sel = '0;
        for (int i = 1; i <= NREQ; i++) begin
            arb_sel = IDW'((int'(last_q) + i) % NREQ);
            if (!win_vld && req[arb_sel]) begin
                win_vld = 1'b1;
                win_id  = arb_sel;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        sub_d     = sub_q;
        gnt_d     = '0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        result_d  = result_q;
        cout_d    = cout_q;
        v_d       = v_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (win_vld) begin
                    state_d = S_CALC;
                    last_d  = win_id;
                    id_d    = win_id;
                    a_d     = a_bus[int'(win_id)*20 +: 20];
                    b_d     = b_bus[int'(win_id)*20 +: 20];
                    sub_d   = sub_bus[win_id];
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_id;
                end
            end
            S_CALC: begin
                state_d   = S_DONE;
                result_d  = add_sum;
                cout_d    = add_cout;
                v_d       = add_v;
                done_d    = 1'b1;
                done_id_d = id_q;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_q    <= LAST_RST;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            v_q       <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            id_q      <= id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sub_q     <= sub_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            v_q       <= v_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign done_id  = done_id_q;
    assign result   = result_q;
    assign res_cout = cout_q;
    assign res_v    = v_q;
    assign busy     = busy_q;
endmodule

`default_nettype wire

// File: tb/tb_addsub_share_arbiter.sv
// =====================================================================
// tb_addsub_share_arbiter: directed self-checking bench for the shared
// add/sub arbiter. Revision: 1.0
// =====================================================================
`default_nettype none

module tb_addsub_share_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req, sub_bus;
    logic [NREQ*20-1:0] a_bus, b_bus;
    logic [NREQ-1:0]    gnt;
    logic               done, res_cout, res_v, busy;
    logic [IDW-1:0]     done_id;
    logic [19:0]        result;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt;

    addsub_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .sub_bus  (sub_bus),
        .a_bus    (a_bus),
        .b_bus    (b_bus),
        .gnt      (gnt),
        .done     (done),
        .done_id  (done_id),
        .result   (result),
        .res_cout (res_cout),
        .res_v    (res_v),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [19:0] a, input logic [19:0] b, input logic s);
        a_bus[id*20 +: 20] = a;
        b_bus[id*20 +: 20] = b;
        sub_bus[id]        = s;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_gnt"},  32'(gnt),      32'h0);
        check_eq({tag, "_done"}, 32'(done),     32'h0);
        check_eq({tag, "_id"},   32'(done_id),  32'h0);
        check_eq({tag, "_res"},  32'(result),   32'h0);
        check_eq({tag, "_cout"}, 32'(res_cout), 32'h0);
        check_eq({tag, "_v"},    32'(res_v),    32'h0);
        check_eq({tag, "_busy"}, 32'(busy),     32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One isolated operation: gnt in the cycle after req is sampled, done one cycle later
    task automatic do_op(input string tag, input int id, input logic [19:0] a, input logic [19:0] b,
                         input logic s, input logic [19:0] er, input logic ec, input logic ev);
        set_op(id, a, b, s);
        req[id] = 1'b1;
        tick();
        check_eq({tag, "_gnt"},   32'(gnt),  32'(4'b0001 << id));
        check_eq({tag, "_early"}, 32'(done), 32'h0);
        check_eq({tag, "_busy"},  32'(busy), 32'h1);
        req[id] = 1'b0;
        tick();
        check_eq({tag, "_done"},  32'(done),     32'h1);
        check_eq({tag, "_gnt0"},  32'(gnt),      32'h0);
        check_eq({tag, "_id"},    32'(done_id),  32'(id));
        check_eq({tag, "_res"},   32'(result),   32'(er));
        check_eq({tag, "_cout"},  32'(res_cout), 32'(ec));
        check_eq({tag, "_v"},     32'(res_v),    32'(ev));
        tick();
        check_eq({tag, "_pulse"}, 32'(done),     32'h0);
        check_eq({tag, "_idle"},  32'(busy),     32'h0);
        check_eq({tag, "_hold"},  32'(result),   32'(er));
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        sub_bus = '0;
        a_bus   = '0;
        b_bus   = '0;
        repeat (3) tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();
        check_reset_outputs("idle");

        do_op("add",   0, 20'd5,       20'd7, 1'b0, 20'd12,      1'b0, 1'b0);
        do_op("sub",   2, 20'd3,       20'd5, 1'b1, 20'hFFFFE,   1'b0, 1'b0);
        do_op("ovfa",  1, 20'h7FFFF,   20'd1, 1'b0, 20'h80000,   1'b0, 1'b1);
        do_op("ovfs",  1, 20'h80000,   20'd1, 1'b1, 20'h7FFFF,   1'b1, 1'b1);
        do_op("wrap",  3, 20'hFFFFF,   20'd1, 1'b0, 20'h00000,   1'b1, 1'b0);

        // Contention: all four requesting together right after reset
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 20'(100 * i), 20'(i), 1'b0);
        req      = 4'b1111;
        busy_cnt = 0;
        for (int g = 0; g < NREQ; g++) begin
            tick();
            if (busy) busy_cnt++;
            check_eq($sformatf("cont_gnt%0d", g), 32'(gnt), 32'(4'b0001 << g));
            req[g] = 1'b0;
            tick();
            if (busy) busy_cnt++;
            check_eq($sformatf("cont_id%0d", g),  32'(done_id), 32'(g));
            check_eq($sformatf("cont_res%0d", g), 32'(result),  32'(101 * g));
        end
        tick();
        check_eq("cont_idle",     32'(busy),     32'h0);
        check_eq("cont_busy_cnt", 32'(busy_cnt), 32'd8);

        // Fairness: requesters 0 and 3 hold req continuously
        do_reset();
        set_op(0, 20'd10, 20'd1, 1'b0);
        set_op(3, 20'd20, 20'd2, 1'b1);
        req = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq($sformatf("fair_gnt%0d", k), 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h8);
            if (k == 3) req = '0;
            tick();
            check_eq($sformatf("fair_id%0d", k),  32'(done_id), (k % 2 == 0) ? 32'd0 : 32'd3);
            check_eq($sformatf("fair_res%0d", k), 32'(result),  (k % 2 == 0) ? 32'd11 : 32'd18);
        end
        tick();
        check_eq("fair_idle", 32'(busy), 32'h0);

        // Reset while the grant is out: operation is dropped
        set_op(1, 20'd40, 20'd2, 1'b0);
        req[1] = 1'b1;
        tick();
        check_eq("rcalc_gnt", 32'(gnt), 32'h2);
        rst    = 1'b1;
        req[1] = 1'b0;
        tick();
        check_reset_outputs("rcalc");
        rst = 1'b0;
        tick();
        check_eq("rcalc_nodone", 32'(done), 32'h0);
        do_op("after", 1, 20'd40, 20'd2, 1'b0, 20'd42, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/addsub_share_arbiter.md
# addsub_share_arbiter

Time-multiplexes the single 20-bit carry-lookahead add/subtract unit (`carry_lookahead_adder_20bit`) among NREQ requesters in the ODE solver datapath. Arbitration is round-robin. Operands are latched on grant, the operation completes in one cycle, and the result is returned with a one-cycle `done` pulse tagged with the requester ID. The block sits between the solver's step-evaluation units and the shared adder, so each unit does not need its own adder.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester-ID width, equal to ceil(log2(NREQ))
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  request per requester; level, held until granted
- sub_bus  in  NREQ  per-requester op select (1 = a-b, 0 = a+b)
- a_bus  in  NREQ*20  packed operand A; requester i uses bits [20i+19:20i]
- b_bus  in  NREQ*20  packed operand B, same packing
- gnt  out  NREQ  one-hot grant pulse, registered, one cycle
- done  out  1  result-valid pulse, one cycle
- done_id  out  IDW  requester that owns `result`
- result  out  20  two's-complement sum/difference
- res_cout  out  1  adder carry-out
- res_v  out  1  signed overflow
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- Adder instance: cin tied to 0; sub, a and b are driven from the operand registers. Subtraction is in0 + ~in1 + 1, handled inside the adder.
- FSM has three states: IDLE, CALC, DONE.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise, on the clock edge: pick the winner, latch a/b/sub and the winner's ID, set gnt[winner]=1, and go to CALC.
- CALC:
  - gnt is high for this cycle only. Incoming req is ignored.
  - On the clock edge: register the adder sum/cout/v into result/res_cout/res_v, set done=1 and done_id=latched ID, and go to DONE.
- DONE:
  - done is high for this cycle only.
  - If any req bit is set, arbitrate exactly as in IDLE and go to CALC (back-to-back operation). Otherwise go to IDLE.
- Round-robin pointer `last` (IDW bits):
  - Search order is last+1, last+2, … modulo NREQ.
  - `last` is updated to the winner on every grant.
  - Reset value of `last` is NREQ-1, so requester 0 has top priority after reset.
- Requester rules:
  - a/b/sub must be stable while req is high.
  - req must be low in the cycle after gnt is seen high, i.e. by the DONE cycle. If it stays high, it is treated as a new request.
- result/res_cout/res_v/done_id hold their values after done until the next completion.
- busy is registered and equals (state != IDLE).

## Timing
- Reset values: gnt=0, done=0, done_id=0, result=0, res_cout=0, res_v=0, busy=0, state=IDLE, last=NREQ-1, operand registers 0.
- Latency: with req sampled high at edge k (state IDLE), gnt is high during cycle k+1 and done is high during cycle k+2.
- Throughput: one operation per 2 cycles under continuous requests.
- Simultaneous requests: exactly one gnt bit is ever high; losers wait with req held.
- A new req arriving during CALC is not seen until the DONE-cycle arbitration.
- Reset mid-operation (CALC or DONE): the operation is discarded, no done is produced (or it is cleared), outputs return to their reset values, and `last` returns to NREQ-1.
- Arithmetic:
  - Modulo 2^20.
  - res_v=1 if and only if the operands have equal signs (after inverting b for sub) and the result sign differs.
  - res_cout is the raw carry-out; for sub, res_cout=1 means no borrow.

## Test plan
- Single add: req[0], a=5, b=7, sub=0 at edge k -> gnt=0001 in cycle k+1, done in k+2, done_id=0, result=12, res_cout=0, res_v=0.
- Subtract: req[2], a=3, b=5, sub=1 -> result=0xFFFFE, res_cout=0, res_v=0, done_id=2.
- Overflow: req[1], a=0x7FFFF, b=1, sub=0 -> result=0x80000, res_v=1, res_cout=0. Then a=0x80000, b=1, sub=1 -> result=0x7FFFF, res_v=1, res_cout=1.
- Contention after reset: all four req high together, each dropped after its gnt -> grants 0, 1, 2, 3 at 2-cycle spacing; done_id 0, 1, 2, 3; busy stays high for 8 cycles.
- Fairness: req[3] and req[0] held continuously (re-requesting) -> grants alternate 0, 3, 0, 3; neither is starved.
- Reset in CALC: assert rst for one cycle while gnt[1] is high -> no done; all outputs return to reset values. A following req[1] completes normally with gnt[1] as the first grant.
